// File: rtl/smooth_ctrl_pkg.sv
// Shared definitions for the smoothing-filter control path: state encodings are
// exported so the datapath can read back controller status for debug.
package smooth_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_LOAD   = 3'd2,
    ST_MAC    = 3'd3,
    ST_OUT    = 3'd4
  } state_t;

  // True for any state in which a frame is in flight.
  function automatic logic state_busy(input state_t s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/smooth_tap_counter.sv
// Saturating up-counter with synchronous clear, enable and terminal-count flag.
// Used for both the tap index and the channel index of the smoothing controller.
module smooth_tap_counter #(
  parameter int MAX = 3,
  parameter int W   = 2
) (
  input  logic         sys_clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == W'(MAX - 1));

  // Count up on enable, never past MAX-1; clear has priority.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/smooth_mac_controller.sv
// Control FSM for the smoothing-filter datapath. Per ready strobe it walks
// NUM_CH interleaved channels through sample / load / NUM_TAPS MAC cycles /
// output, honouring downstream backpressure and flagging overrun strobes.
module smooth_mac_controller
  import smooth_ctrl_pkg::*;
#(
  parameter int NUM_TAPS = 3,
  parameter int NUM_CH   = 2,
  parameter int TAP_W    = ($clog2(NUM_TAPS) > 0) ? $clog2(NUM_TAPS) : 1,
  parameter int CH_W     = ($clog2(NUM_CH) > 0) ? $clog2(NUM_CH) : 1
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  input  logic             ready,
  input  logic             stage1,
  input  logic             smooth,
  input  logic             out_ready,
  output logic             sclr,
  output logic             addr_sel,
  output logic             mac_en,
  output logic [TAP_W-1:0] factor_sel,
  output logic [CH_W-1:0]  ch_sel,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  state_t           state, state_nxt;
  logic             stage1_q, smooth_q;
  logic             overrun_q;
  logic [TAP_W-1:0] tap;
  logic [CH_W-1:0]  ch;
  logic             tap_tc, ch_tc;
  logic             tap_clr, tap_en, ch_clr, ch_en;
  logic             accept;

  // A strobe only starts a frame when the controller is idle.
  assign accept = (state == ST_IDLE) && ready;

  smooth_tap_counter #(.MAX(NUM_TAPS), .W(TAP_W)) u_tap_cnt (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .clr     (tap_clr),
    .en      (tap_en),
    .cnt     (tap),
    .tc      (tap_tc)
  );

  smooth_tap_counter #(.MAX(NUM_CH), .W(CH_W)) u_ch_cnt (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .clr     (ch_clr),
    .en      (ch_en),
    .cnt     (ch),
    .tc      (ch_tc)
  );

  // State register.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Mode is latched at frame start so mid-frame input changes cannot disturb it.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      stage1_q <= 1'b0;
      smooth_q <= 1'b0;
    end else if (accept) begin
      stage1_q <= stage1;
      smooth_q <= smooth;
    end
  end

  // One-cycle overrun pulse for any strobe arriving while a frame is running.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= ready && (state != ST_IDLE);
    end
  end

  // Next-state logic and counter control.
  always_comb begin
    state_nxt = state;
    tap_clr   = 1'b0;
    tap_en    = 1'b0;
    ch_clr    = 1'b0;
    ch_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ready) begin
          state_nxt = ST_SAMPLE;
          ch_clr    = 1'b1;
        end
      end
      ST_SAMPLE: begin
        state_nxt = stage1_q ? ST_OUT : ST_LOAD;
      end
      ST_LOAD: begin
        state_nxt = smooth_q ? ST_MAC : ST_OUT;
        tap_clr   = 1'b1;
      end
      ST_MAC: begin
        if (tap_tc) begin
          state_nxt = ST_OUT;
          tap_clr   = 1'b1;
        end else begin
          tap_en    = 1'b1;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          if (ch_tc) begin
            state_nxt = ST_IDLE;
            ch_clr    = 1'b1;
          end else begin
            state_nxt = ST_SAMPLE;
            ch_en     = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Moore output decode from registered state and counters.
  always_comb begin
    sclr       = 1'b0;
    addr_sel   = 1'b0;
    mac_en     = 1'b0;
    factor_sel = '0;
    ch_sel     = '0;
    out_valid  = 1'b0;
    case (state)
      ST_SAMPLE: begin
        ch_sel = ch;
      end
      ST_LOAD: begin
        sclr     = 1'b1;
        addr_sel = 1'b1;
        ch_sel   = ch;
      end
      ST_MAC: begin
        mac_en     = 1'b1;
        factor_sel = tap;
        ch_sel     = ch;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        ch_sel    = ch;
      end
      default: begin
        ch_sel = '0;
      end
    endcase
  end

  assign busy    = state_busy(state);
  assign overrun = overrun_q;

endmodule
